// File: rtl/fifo_ser_pkg.sv
// Shared types and constants for the FIFO word serializer.
package fifo_ser_pkg;

   localparam int FIFO_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } ser_state_t;

endpackage

// File: rtl/ser_shift_reg.sv
// Parallel-load shift register; shifts toward the output end, filling with zero.
module ser_shift_reg #(
   parameter int WIDTH     = 16,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_shift,
   output logic             o_bit
);

   logic [WIDTH-1:0] r_shreg;

   // Load takes priority so a reload on the final beat starts the next word cleanly.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shreg <= '0;
      end else if (i_load) begin
         r_shreg <= i_data;
      end else if (i_shift) begin
         if (MSB_FIRST != 0) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
         end else begin
            r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
         end
      end else begin
         r_shreg <= r_shreg;
      end
   end

   assign o_bit = (MSB_FIRST != 0) ? r_shreg[WIDTH-1] : r_shreg[0];

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops words from a FIFO and streams them bit-serially over valid/ready.
// Define FIFO_WORD_SERIALIZER_PARITY_EN to append an even-parity beat per word.
module fifo_word_serializer
   import fifo_ser_pkg::*;
#(
   parameter int WIDTH     = FIFO_WIDTH,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_emp,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_pop,
   output logic             ser_data,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_last,
   output logic             busy
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

   ser_state_t       r_state;
   logic [CNT_W-1:0] r_bit_cnt;
   logic             w_data_beat;
   logic             w_last_data;
   logic             w_word_done;
   logic             w_pop;
   logic             w_shift;
   logic             w_shbit;

   assign w_data_beat = (r_state == SHIFT);
   assign w_last_data = w_data_beat & (r_bit_cnt == '0);
   assign w_shift     = w_data_beat & ser_ready;

`ifdef FIFO_WORD_SERIALIZER_PARITY_EN
   logic r_parity;

   // Even parity of the word, captured alongside the data at load time.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_parity <= 1'b0;
      end else if (w_pop) begin
         r_parity <= ^fifo_data;
      end else begin
         r_parity <= r_parity;
      end
   end

   assign w_word_done = (r_state == PARITY) & ser_ready;
   assign ser_valid   = w_data_beat | (r_state == PARITY);
   assign ser_data    = (r_state == PARITY) ? r_parity : w_shbit;
   assign ser_last    = (r_state == PARITY);
`else
   assign w_word_done = w_last_data & ser_ready;
   assign ser_valid   = w_data_beat;
   assign ser_data    = w_shbit;
   assign ser_last    = w_last_data;
`endif

   // Popping during reset would lose a word that is about to be discarded.
   assign w_pop    = ~rst & ~fifo_emp & ((r_state == IDLE) | w_word_done);
   assign fifo_pop = w_pop;
   assign busy     = (r_state != IDLE);

   // Sequencing: load on pop, count beats down, reload or retire at the word end.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_bit_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_state   <= SHIFT;
                  r_bit_cnt <= CNT_LOAD;
               end else begin
                  r_state   <= IDLE;
               end
            end
            SHIFT: begin
               if (!ser_ready) begin
                  r_state <= SHIFT;
               end else if (r_bit_cnt != '0) begin
                  r_bit_cnt <= r_bit_cnt - CNT_W'(1);
`ifdef FIFO_WORD_SERIALIZER_PARITY_EN
               end else begin
                  r_state <= PARITY;
               end
            end
            PARITY: begin
               if (!ser_ready) begin
                  r_state <= PARITY;
               end else if (w_pop) begin
                  r_state   <= SHIFT;
                  r_bit_cnt <= CNT_LOAD;
               end else begin
                  r_state <= IDLE;
               end
            end
`else
               end else if (w_pop) begin
                  r_bit_cnt <= CNT_LOAD;
               end else begin
                  r_state <= IDLE;
               end
            end
`endif
            default: begin
               r_state   <= IDLE;
               r_bit_cnt <= '0;
            end
         endcase
      end
   end

   ser_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_pop),
      .i_data  (fifo_data),
      .i_shift (w_shift),
      .o_bit   (w_shbit)
   );

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
Downstream consumer of the 4-deep 16-bit push/pop FIFO. It pops one word whenever the FIFO is non-empty and the block is free. It then shifts the word out one bit per accepted beat on a valid/ready serial interface. Back-to-back words stream with no bubble beat.

Parameters:
WIDTH, 16, word width; must equal the FIFO data width; must be ≥2.
MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
fifo_emp  input  1  FIFO empty flag.
fifo_data  input  WIDTH  FIFO data_out; treated as valid in the same cycle fifo_pop is asserted.
fifo_pop  output  1  pop strobe to the FIFO; combinational; never asserted while fifo_emp=1.
ser_data  output  1  current serial bit.
ser_valid  output  1  ser_data is valid.
ser_ready  input  1  sink accepts the beat when ser_valid & ser_ready.
ser_last  output  1  high on the final beat of a word.
busy  output  1  high when the state is not IDLE.

Behaviour:
- Reset (synchronous, active-high) sets: state=IDLE; shift register = 0; bit counter = 0. Outputs after reset: ser_valid=0, ser_last=0, busy=0, fifo_pop=0, ser_data=0.
- States:
  - IDLE: when fifo_emp=0, assert fifo_pop, capture fifo_data into the shift register, load bit_cnt=WIDTH-1, go to SHIFT.
  - SHIFT: ser_valid=1. ser_data = shreg[WIDTH-1] if MSB_FIRST, else shreg[0]. On each accepted beat, shift by one toward the output and decrement bit_cnt.
  - SHIFT, ser_last: high when bit_cnt==0 (and PARITY_EN is undefined).
  - SHIFT, final beat accepted, fifo_emp=0: assert fifo_pop in that same cycle, reload the shift register and bit_cnt, stay in SHIFT. There is no bubble.
  - SHIFT, final beat accepted, fifo_emp=1: go to IDLE.
- Latency: pop in cycle T; first ser_valid in cycle T+1.
- Throughput: one bit per cycle while ser_ready=1. A word takes WIDTH beats.
- Backpressure: while ser_valid=1 and ser_ready=0, ser_data, ser_last, shreg and bit_cnt hold stable. ser_valid must not drop until the beat is accepted.
- fifo_pop is at most one cycle per word. It is never asserted during the non-final beats of SHIFT. It is never asserted while fifo_emp=1.
- bit_cnt width: $clog2(WIDTH). The decrement never wraps, because reload or exit happens at 0.
- Reset mid-word: the partial word is discarded (already popped, not re-sent). The first output after reset starts a fresh word.
- fifo_emp toggling while in SHIFT is ignored until the final beat.

Optional Feature:
Macro: FIFO_WORD_SERIALIZER_PARITY_EN.
- Defined: adds state PARITY, entered after the last data beat is accepted.
  - In PARITY the block sends one extra beat carrying even parity, the XOR of all WIDTH bits. The parity is computed at load time and held in a register.
  - ser_last is on the parity beat, not on data bit 0 of the count.
  - The reload/pop decision moves to acceptance of the parity beat.
  - A word takes WIDTH+1 beats.
- Undefined: no PARITY state and no parity register; behaviour as above.

Decomposition:
- Package fifo_ser_pkg holds:
  - state enum: IDLE, SHIFT, PARITY (PARITY is unused when the macro is off);
  - default WIDTH constant 16 shared with the FIFO.
- One natural sub-module, ser_shift_reg: a parallel-load shift register with load, shift enable and direction parameter, exposing the output bit.
- FSM, bit counter and pop logic stay in the top.

Test Plan:
- Single word: FIFO model holds 0xA5C3, ser_ready=1, MSB_FIRST=1.
  - Response: fifo_pop for exactly 1 cycle, then 16 beats 1010_0101_1100_0011, ser_last on beat 16, then IDLE with busy=0.
- Back-to-back: FIFO holds 0xFFFF then 0x0000.
  - Response: 32 consecutive valid beats, the second pop coincides with beat 16, and there is no idle cycle between the words.
- Backpressure: word 0x8001 with ser_ready low for 3 cycles on beat 1 and on beat 16.
  - Response: outputs hold stable during the stalls, the bit order is preserved, and there is still exactly one pop.
- Empty FIFO: fifo_emp=1 for 20 cycles.
  - Response: fifo_pop=0, ser_valid=0, busy=0 throughout.
- Reset mid-word: assert rst at beat 7 of 0x1234 for 1 cycle while the FIFO holds 0x00FF.
  - Response: next cycle ser_valid=0, then 0x00FF is serialized from its first bit and the 0x1234 remainder is never sent.
- Parity with FIFO_WORD_SERIALIZER_PARITY_EN defined: word 0x0001.
  - Response: 17 beats, beat 17 carries 1 with ser_last.
  - Word 0xA5C3 gives a parity beat of 0.
